// File: rtl/flash_pkg.sv
// Shared definitions for the SPI flash front-end and the SPIFlashModule wrapper.
package flash_pkg;

    localparam int unsigned FLASH_ADDR_W = 24;
    localparam int unsigned FLASH_DATA_W = 32;

    // State encoding kept as plain constants so legacy wrappers can decode it.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCEPT = 2'd1;
    localparam logic [1:0] ST_BUSY   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

endpackage

// File: rtl/flash_timeout_ctr.sv
// Saturating cycle counter: expired goes high once LIMIT cycles have been counted since clear.
module flash_timeout_ctr #(
    parameter int unsigned LIMIT = 1048576
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = $clog2(LIMIT) + 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q >= LAST);

endmodule

// File: rtl/flash_req_bridge.sv
// CPU valid/ready request front-end for SPIFlashModule; all flash_* outputs are registered.
module flash_req_bridge
    import flash_pkg::*;
#(
    parameter int unsigned ADDR_W = FLASH_ADDR_W,
    parameter int unsigned DATA_W = FLASH_DATA_W,
    parameter int unsigned TIMEOUT = 1048576,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT = 'hFFFFFC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              flash_en,
    output logic              flash_write,
    output logic [ADDR_W-1:0] flash_addr,
    output logic [DATA_W-1:0] flash_data_in,
    input  logic [DATA_W-1:0] flash_data_out,
    input  logic              flash_ready,
    output logic              busy
);

    logic [1:0]        state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              flash_en_q, flash_en_d;
    logic              flash_write_q, flash_write_d;
    logic [ADDR_W-1:0] flash_addr_q, flash_addr_d;
    logic [DATA_W-1:0] flash_data_in_q, flash_data_in_d;
    logic              busy_q, busy_d;
    logic              tmo_clear, tmo_enable, tmo_expired;

    flash_timeout_ctr #(
        .LIMIT(TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    assign tmo_enable = (state_q == ST_ACCEPT) || (state_q == ST_BUSY);
    assign tmo_clear  = (state_d != state_q);

    always_comb begin
        state_d         = state_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_rdata_d     = rsp_rdata_q;
        rsp_err_d       = rsp_err_q;
        flash_en_d      = flash_en_q;
        flash_write_d   = flash_write_q;
        flash_addr_d    = flash_addr_q;
        flash_data_in_d = flash_data_in_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    if (req_addr > ADDR_LIMIT) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d         = ST_ACCEPT;
                        flash_en_d      = 1'b1;
                        flash_write_d   = req_write;
                        flash_addr_d    = {req_addr[ADDR_W-1:2], 2'b00};
                        flash_data_in_d = req_write ? req_wdata : '0;
                    end
                end
            end
            ST_ACCEPT, ST_BUSY: begin
                // ACCEPT waits for the controller to go busy; BUSY waits for it to finish.
                if ((state_q == ST_ACCEPT) && !flash_ready) begin
                    state_d = ST_BUSY;
                end else if ((state_q == ST_BUSY) && flash_ready) begin
                    state_d       = ST_RESP;
                    flash_en_d    = 1'b0;
                    flash_write_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b0;
                    rsp_rdata_d   = flash_write_q ? '0 : flash_data_out;
                end else if (tmo_expired) begin
                    state_d       = ST_RESP;
                    flash_en_d    = 1'b0;
                    flash_write_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_rdata_d   = '0;
                end
            end
            default: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            req_ready_q     <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_rdata_q     <= '0;
            rsp_err_q       <= 1'b0;
            flash_en_q      <= 1'b0;
            flash_write_q   <= 1'b0;
            flash_addr_q    <= '0;
            flash_data_in_q <= '0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            req_ready_q     <= req_ready_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_rdata_q     <= rsp_rdata_d;
            rsp_err_q       <= rsp_err_d;
            flash_en_q      <= flash_en_d;
            flash_write_q   <= flash_write_d;
            flash_addr_q    <= flash_addr_d;
            flash_data_in_q <= flash_data_in_d;
            busy_q          <= busy_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_err       = rsp_err_q;
    assign flash_en      = flash_en_q;
    assign flash_write   = flash_write_q;
    assign flash_addr    = flash_addr_q;
    assign flash_data_in = flash_data_in_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_flash_req_bridge.sv
// Directed bench for flash_req_bridge with a response scoreboard (TIMEOUT shortened to 16).
module tb_flash_req_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [23:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        flash_en, flash_write;
    logic [23:0] flash_addr;
    logic [31:0] flash_data_in, flash_data_out;
    logic        flash_ready, busy;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    flash_req_bridge #(
        .ADDR_W(24),
        .DATA_W(32),
        .TIMEOUT(16),
        .ADDR_LIMIT(24'hFFFFFC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .flash_en       (flash_en),
        .flash_write    (flash_write),
        .flash_addr     (flash_addr),
        .flash_data_in  (flash_data_in),
        .flash_data_out (flash_data_out),
        .flash_ready    (flash_ready),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input string tag, input logic wr, input logic [23:0] addr,
                            input logic [31:0] wdata);
        int n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_req_ready"}, req_ready, 1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic collect(input string tag);
        int   n = 0;
        rsp_t e;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_rsp_valid"}, rsp_valid, 1);
        chk({tag, "_sb_pending"}, (sb.size() > 0), 1);
        e = (sb.size() > 0) ? sb.pop_front() : '1;
        chk({tag, "_rdata"}, rsp_rdata, e.rdata);
        chk({tag, "_err"}, rsp_err, e.err);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "_rsp_clear"}, rsp_valid, 0);
        chk({tag, "_idle_ready"}, req_ready, 1);
        chk({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        rsp_t e;
        logic [31:0] held;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0; flash_data_out = '0; flash_ready = 1'b1;
        repeat (3) tick();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_flash_en", flash_en, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        tick();
        chk("post_rst_ready", req_ready, 1);

        // Read with three busy cycles.
        send_req("t1", 1'b0, 24'h000010, 32'h0);
        sb.push_back('{rdata: 32'hDEADBEEF, err: 1'b0});
        chk("t1_flash_en", flash_en, 1);
        chk("t1_addr", flash_addr, 24'h000010);
        chk("t1_write", flash_write, 0);
        chk("t1_data_in", flash_data_in, 0);
        chk("t1_req_ready", req_ready, 0);
        flash_ready = 1'b0;
        repeat (3) tick();
        chk("t1_hold_en", flash_en, 1);
        flash_ready = 1'b1; flash_data_out = 32'hDEADBEEF;
        tick();
        chk("t1_latency", rsp_valid, 1);
        chk("t1_en_drop", flash_en, 0);
        collect("t1");

        // Unaligned write: low address bits forced to zero.
        send_req("t2", 1'b1, 24'h000013, 32'h12345678);
        sb.push_back('{rdata: 32'h0, err: 1'b0});
        chk("t2_addr", flash_addr, 24'h000010);
        chk("t2_data_in", flash_data_in, 32'h12345678);
        chk("t2_write", flash_write, 1);
        flash_ready = 1'b0;
        repeat (2) tick();
        chk("t2_write_hold", flash_write, 1);
        flash_ready = 1'b1; flash_data_out = 32'hAAAA5555;
        tick();
        chk("t2_latency", rsp_valid, 1);
        chk("t2_write_drop", flash_write, 0);
        collect("t2");

        // Out-of-range read rejected without touching the flash.
        send_req("t3", 1'b0, 24'hFFFFFF, 32'h0);
        sb.push_back('{rdata: 32'h0, err: 1'b1});
        chk("t3_no_en", flash_en, 0);
        chk("t3_rsp_next", rsp_valid, 1);
        collect("t3");

        // Highest legal address is accepted.
        send_req("t3b", 1'b0, 24'hFFFFFC, 32'h0);
        sb.push_back('{rdata: 32'h0BADF00D, err: 1'b0});
        chk("t3b_en", flash_en, 1);
        chk("t3b_addr", flash_addr, 24'hFFFFFC);
        flash_ready = 1'b0; tick();
        flash_ready = 1'b1; flash_data_out = 32'h0BADF00D; tick();
        collect("t3b");

        // Controller never goes busy: timeout 16 cycles after ACCEPT entry.
        send_req("t4", 1'b0, 24'h000100, 32'h0);
        sb.push_back('{rdata: 32'h0, err: 1'b1});
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("t4_still_en", {flash_en, rsp_valid}, 2'b10);
        end
        tick();
        chk("t4_tmo_en", flash_en, 0);
        chk("t4_tmo_valid", rsp_valid, 1);
        collect("t4");

        // Controller stuck busy: counter restarts on BUSY entry.
        send_req("t4b", 1'b1, 24'h000200, 32'hCAFEF00D);
        sb.push_back('{rdata: 32'h0, err: 1'b1});
        flash_ready = 1'b0;
        for (int i = 1; i < 17; i++) begin
            tick();
            chk("t4b_still_en", {flash_en, rsp_valid}, 2'b10);
        end
        tick();
        chk("t4b_tmo_en", {flash_en, flash_write}, 2'b00);
        flash_ready = 1'b1;
        collect("t4b");

        // Response backpressure, then a request one cycle after the handshake.
        send_req("t5", 1'b0, 24'h000020, 32'h0);
        flash_ready = 1'b0; tick();
        flash_ready = 1'b1; flash_data_out = 32'h5A5A1234; tick();
        sb.push_back('{rdata: 32'h5A5A1234, err: 1'b0});
        flash_data_out = 32'hFFFFFFFF;
        held = rsp_rdata;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t5_stall", {rsp_valid, req_ready, (rsp_rdata == held)}, 3'b101);
        end
        e = sb.pop_front();
        chk("t5_rdata", rsp_rdata, e.rdata);
        chk("t5_err", rsp_err, e.err);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 24'h000040;
        tick();
        rsp_ready = 1'b0;
        chk("t5_not_yet", {rsp_valid, flash_en, req_ready}, 3'b001);
        tick();
        req_valid = 1'b0;
        chk("t5_next_acc", flash_en, 1);
        chk("t5_next_addr", flash_addr, 24'h000040);

        // Reset while BUSY discards the operation.
        flash_ready = 1'b0;
        tick();
        chk("t6_busy", {flash_en, busy}, 2'b11);
        reset = 1'b1;
        tick();
        chk("t6_rst_out", {flash_en, rsp_valid, req_ready, busy}, 4'b0000);
        reset = 1'b0; flash_ready = 1'b1;
        tick();
        chk("t6_ready_after", req_ready, 1);
        chk("t6_no_rsp", rsp_valid, 0);

        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
